// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART TX byte
// input among N_PORTS byte-stream requesters, with a single registered output
// stage. A granted port keeps the transmitter until it sends its tlast byte or
// until MAX_BURST bytes have gone through, whichever comes first.

module uart_tx_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int MAX_BURST = 16,
    localparam int ID_W     = $clog2(N_PORTS)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [8*N_PORTS-1:0]   S_axis_tdata,
    input  logic [N_PORTS-1:0]     S_axis_tvalid,
    input  logic [N_PORTS-1:0]     S_axis_tlast,
    output logic [N_PORTS-1:0]     S_axis_tready,
    output logic [7:0]             M_axis_tdata,
    output logic                   M_axis_tvalid,
    input  logic                   M_axis_tready,
    output logic [ID_W-1:0]        Grant_id,
    output logic                   Busy
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [7:0]      burst_cnt;
    logic [ID_W-1:0] next_grant;
    logic            grant_found;
    logic            grant_load;
    logic            s_hs;
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            burst_done;

    // Round-robin search: first valid port after the current pointer, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        next_grant  = Grant_id;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = (int'(Grant_id) + k) % N_PORTS;
            if (!grant_found && S_axis_tvalid[idx]) begin
                grant_found = 1'b1;
                next_grant  = ID_W'(idx);
            end
        end
    end

    // Select the granted port's stream and detect the end of its burst window.
    always_comb begin
        sel_valid  = S_axis_tvalid[Grant_id];
        sel_last   = S_axis_tlast[Grant_id];
        sel_data   = S_axis_tdata[int'(Grant_id)*8 +: 8];
        burst_done = (({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST));
    end

    // Next-state and handshake logic; tready only opens when the output register is empty.
    always_comb begin
        next_state    = state;
        grant_load    = 1'b0;
        s_hs          = 1'b0;
        S_axis_tready = '0;
        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    next_state = ST_GRANT;
                    grant_load = 1'b1;
                end
            end
            ST_GRANT: begin
                S_axis_tready[Grant_id] = !M_axis_tvalid;
                s_hs = sel_valid && !M_axis_tvalid;
                if (s_hs && (sel_last || burst_done)) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant pointer and per-grant byte counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Grant_id  <= ID_W'(N_PORTS - 1);
            burst_cnt <= 8'd0;
        end else if (grant_load) begin
            Grant_id  <= next_grant;
            burst_cnt <= 8'd0;
        end else if (s_hs) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end

    // Output register: drain on M handshake, otherwise load on S handshake; data holds after drain.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            M_axis_tdata  <= 8'h00;
            M_axis_tvalid <= 1'b0;
        end else if (M_axis_tvalid && M_axis_tready) begin
            M_axis_tvalid <= 1'b0;
        end else if (s_hs) begin
            M_axis_tdata  <= sel_data;
            M_axis_tvalid <= 1'b1;
        end
    end

    assign Busy = (state == ST_GRANT) || M_axis_tvalid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with per-port byte
// sources, an output byte log and hand-computed expected streams.

module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic         Clk;
    logic         Rst = 1'b1;
    logic [31:0]  s_tdata = '0;
    logic [3:0]   s_tvalid = '0;
    logic [3:0]   s_tlast = '0;
    logic [3:0]   s_tready;
    logic [7:0]   m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [1:0]   grant_id;
    logic         busy;

    logic [8:0]   src_mem [N][64];
    int           src_head [N];
    int           src_tail [N];
    logic [7:0]   out_mem [256];
    int           out_cnt = 0;
    int           hs_port [256];
    int           hs_cnt = 0;

    int           total = 0;
    int           bad = 0;

    uart_tx_arbiter #(.N_PORTS(4), .MAX_BURST(16)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .S_axis_tdata  (s_tdata),
        .S_axis_tvalid (s_tvalid),
        .S_axis_tlast  (s_tlast),
        .S_axis_tready (s_tready),
        .M_axis_tdata  (m_tdata),
        .M_axis_tvalid (m_tvalid),
        .M_axis_tready (m_tready),
        .Grant_id      (grant_id),
        .Busy          (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Source/sink model: present queue heads at negedge, log handshakes just before posedge.
    initial begin
        for (int p = 0; p < N; p++) begin
            src_head[p] = 0;
            src_tail[p] = 0;
        end
        forever begin
            @(negedge Clk);
            for (int p = 0; p < N; p++) begin
                if (src_head[p] != src_tail[p]) begin
                    s_tvalid[p]       = 1'b1;
                    s_tdata[p*8 +: 8] = src_mem[p][src_head[p]][7:0];
                    s_tlast[p]        = src_mem[p][src_head[p]][8];
                end else begin
                    s_tvalid[p]       = 1'b0;
                    s_tdata[p*8 +: 8] = 8'h00;
                    s_tlast[p]        = 1'b0;
                end
            end
            #4;
            if (!Rst) begin
                for (int p = 0; p < N; p++) begin
                    if (s_tvalid[p] && s_tready[p]) begin
                        hs_port[hs_cnt] = p;
                        hs_cnt++;
                        src_head[p]++;
                    end
                end
                if (m_tvalid && m_tready) begin
                    out_mem[out_cnt] = m_tdata;
                    out_cnt++;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int port, input logic [7:0] data, input logic last);
        src_mem[port][src_tail[port]] = {last, data};
        src_tail[port]++;
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        #1;
        Rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_head[p] = 0;
            src_tail[p] = 0;
        end
        repeat (2) @(negedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic wait_out(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (out_cnt < target && n < budget) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check_output(tag, 32'(out_cnt >= target), 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        int base;
        int hbase;
        logic hold_ok;
        logic [7:0] exp_rr [8];
        logic [7:0] exp_burst [22];

        // Reset values.
        m_tready = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        check_output("rst_tready", 32'(s_tready), 32'h0);
        check_output("rst_mvalid", 32'(m_tvalid), 32'h0);
        check_output("rst_mdata", 32'(m_tdata), 32'h00);
        check_output("rst_grant", 32'(grant_id), 32'd3);
        check_output("rst_busy", 32'(busy), 32'h0);
        Rst = 1'b0;

        // Single 3-byte message from port 0.
        $display("[TB] port0 three-byte message");
        base = out_cnt;
        apply_stimulus(0, 8'h41, 1'b0);
        apply_stimulus(0, 8'h42, 1'b0);
        apply_stimulus(0, 8'h43, 1'b1);
        wait_out(base + 3, 60, "msg3_timeout");
        check_output("msg3_b0", 32'(out_mem[base]), 32'h41);
        check_output("msg3_b1", 32'(out_mem[base + 1]), 32'h42);
        check_output("msg3_b2", 32'(out_mem[base + 2]), 32'h43);
        check_output("msg3_grant", 32'(grant_id), 32'd0);
        check_output("msg3_busy", 32'(busy), 32'h0);

        // Ports 0 and 2 at once: whole messages, no interleaving.
        $display("[TB] ports 0 and 2 contending");
        apply_reset();
        base  = out_cnt;
        hbase = hs_cnt;
        apply_stimulus(0, 8'h10, 1'b0);
        apply_stimulus(0, 8'h11, 1'b1);
        apply_stimulus(2, 8'h20, 1'b0);
        apply_stimulus(2, 8'h21, 1'b1);
        wait_out(base + 4, 60, "pair_timeout");
        check_output("pair_b0", 32'(out_mem[base]), 32'h10);
        check_output("pair_b1", 32'(out_mem[base + 1]), 32'h11);
        check_output("pair_b2", 32'(out_mem[base + 2]), 32'h20);
        check_output("pair_b3", 32'(out_mem[base + 3]), 32'h21);
        check_output("pair_port0", 32'(hs_port[hbase + 1]), 32'd0);
        check_output("pair_port2", 32'(hs_port[hbase + 2]), 32'd2);
        check_output("pair_grant", 32'(grant_id), 32'd2);

        // All four ports with 1-byte messages: 0,1,2,3,0,1,2,3.
        $display("[TB] round robin over all ports");
        apply_reset();
        base = out_cnt;
        for (int p = 0; p < N; p++) begin
            apply_stimulus(p, 8'h30 + 8'(p), 1'b1);
            apply_stimulus(p, 8'h40 + 8'(p), 1'b1);
            exp_rr[p]     = 8'h30 + 8'(p);
            exp_rr[p + 4] = 8'h40 + 8'(p);
        end
        wait_out(base + 8, 120, "rr_timeout");
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("rr_b%0d", i), 32'(out_mem[base + i]), 32'(exp_rr[i]));
        end

        // Port 1 never sends tlast: forced release after 16 bytes lets port 3 in.
        $display("[TB] burst limit");
        apply_reset();
        base = out_cnt;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 8'h60 + 8'(i), 1'b0);
        end
        apply_stimulus(3, 8'hA0, 1'b0);
        apply_stimulus(3, 8'hA1, 1'b1);
        for (int i = 0; i < 16; i++) exp_burst[i] = 8'h60 + 8'(i);
        exp_burst[16] = 8'hA0;
        exp_burst[17] = 8'hA1;
        for (int i = 0; i < 4; i++) exp_burst[18 + i] = 8'h70 + 8'(i);
        wait_out(base + 22, 300, "burst_timeout");
        for (int i = 0; i < 22; i++) begin
            check_output($sformatf("burst_b%0d", i), 32'(out_mem[base + i]), 32'(exp_burst[i]));
        end
        check_output("burst_grant", 32'(grant_id), 32'd1);
        check_output("burst_busy", 32'(busy), 32'h1);

        // UART stalled for 50 cycles with 55 held.
        $display("[TB] output backpressure");
        apply_reset();
        m_tready = 1'b0;
        base = out_cnt;
        apply_stimulus(0, 8'h55, 1'b1);
        apply_stimulus(0, 8'h56, 1'b1);
        for (int n = 0; n < 20 && !m_tvalid; n++) begin
            @(negedge Clk);
            #1;
        end
        check_output("stall_loaded", 32'(m_tvalid), 32'h1);
        hold_ok = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            #1;
            if (!(m_tvalid === 1'b1 && m_tdata === 8'h55 && s_tready === 4'h0)) hold_ok = 1'b0;
        end
        check_output("stall_hold", 32'(hold_ok), 32'h1);
        check_output("stall_mdata", 32'(m_tdata), 32'h55);
        check_output("stall_grant", 32'(grant_id), 32'd0);
        m_tready = 1'b1;
        wait_out(base + 2, 40, "stall_timeout");
        check_output("stall_b0", 32'(out_mem[base]), 32'h55);
        check_output("stall_b1", 32'(out_mem[base + 1]), 32'h56);

        // Reset in the middle of port 2's message.
        $display("[TB] reset mid-message");
        apply_reset();
        m_tready = 1'b0;
        apply_stimulus(2, 8'h77, 1'b0);
        apply_stimulus(2, 8'h78, 1'b1);
        for (int n = 0; n < 20 && !m_tvalid; n++) begin
            @(negedge Clk);
            #1;
        end
        check_output("mid_loaded", 32'(m_tvalid), 32'h1);
        check_output("mid_grant2", 32'(grant_id), 32'd2);
        Rst = 1'b1;
        apply_stimulus(0, 8'h90, 1'b1);
        @(negedge Clk);
        #1;
        check_output("mid_rst_tready", 32'(s_tready), 32'h0);
        check_output("mid_rst_mvalid", 32'(m_tvalid), 32'h0);
        check_output("mid_rst_mdata", 32'(m_tdata), 32'h00);
        check_output("mid_rst_grant", 32'(grant_id), 32'd3);
        check_output("mid_rst_busy", 32'(busy), 32'h0);
        base  = out_cnt;
        hbase = hs_cnt;
        m_tready = 1'b1;
        Rst = 1'b0;
        wait_out(base + 2, 40, "mid_timeout");
        check_output("mid_port0_first", 32'(hs_port[hbase]), 32'd0);
        check_output("mid_b0", 32'(out_mem[base]), 32'h90);
        check_output("mid_b1", 32'(out_mem[base + 1]), 32'h78);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
